sensor_vote_monitor: RTL

SENSOR_VOTE_MONITOR -- requirements
Module: sensor_vote_monitor

---
 rtl/sensor_vote_pkg.sv | 25 ++
 rtl/sensor_debounce.sv | 86 ++++++++
 rtl/sensor_vote_monitor.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sensor_vote_pkg.sv
// -----------------------------------------------------------------------------
// sensor_vote_pkg
// Holds the types and constants that the sensor vote monitor and its
// per-sensor debouncer share:
//   state_e      - monitor FSM states (IDLE, MONITOR, PENDING, ALARM)
//   TRIPS_SAT    - value at which the alarm-entry counter stops counting
//   count_width  - bits needed to hold a popcount of n sensors, clog2(n+1)
// -----------------------------------------------------------------------------
package sensor_vote_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_PENDING = 2'd2,
    ST_ALARM   = 2'd3
  } state_e;

  localparam logic [7:0] TRIPS_SAT = 8'd255;

  // A popcount of n bits ranges over 0..n, so it needs clog2(n+1) bits.
  function automatic int count_width(input int n_sensors);
    return $clog2(n_sensors + 1);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// -----------------------------------------------------------------------------
// sensor_debounce
// One sensor channel: a two-flop synchroniser for the raw asynchronous input,
// optionally followed by a debouncer.
//
// Build option: SENSOR_VOTE_MONITOR_DEBOUNCE_EN
//   defined   - the output only takes the synchronised value once that value
//               has disagreed with the output for DEBOUNCE consecutive cycles;
//               any cycle of agreement restarts the run at 0.
//   undefined - the output is the synchronised bit; DEBOUNCE is ignored and
//               no run counter is built.
//
// Ports:
//   Clock   in  rising-edge clock
//   Resetn  in  asynchronous active-low reset
//   x_raw   in  raw asynchronous sensor bit
//   x_db    out synchronised (and, if enabled, debounced) sensor bit
// -----------------------------------------------------------------------------
module sensor_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic x_raw,
  output logic x_db
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Two-flop synchroniser; nothing downstream looks at x_raw directly.
  always_comb begin
    sync1_d = x_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef SENSOR_VOTE_MONITOR_DEBOUNCE_EN
  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE);

  logic       db_q, db_d;
  logic [7:0] run_q, run_d;
  logic [7:0] run_inc;

  // run_q counts the disagreement cycles already seen; the flip happens on
  // the edge that completes the DEBOUNCE-th one. The run never exceeds
  // DEBOUNCE-1 so eight bits cover the full 1..255 range.
  always_comb begin
    db_d    = db_q;
    run_d   = 8'd0;
    run_inc = run_q + 8'd1;
    if (sync2_q != db_q) begin
      if (run_inc >= DB_LIMIT) begin
        db_d  = sync2_q;
        run_d = 8'd0;
      end else begin
        run_d = run_inc;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      db_q  <= 1'b0;
      run_q <= 8'd0;
    end else begin
      db_q  <= db_d;
      run_q <= run_d;
    end
  end

  assign x_db = db_q;
`else
  assign x_db = sync2_q;
`endif

endmodule

// File: rtl/sensor_vote_monitor.sv
// -----------------------------------------------------------------------------
// sensor_vote_monitor
// Votes across N_SENSORS synchronised/debounced sensor inputs. When at least
// THRESH sensors are active for PERSIST consecutive cycles the monitor
// latches an alarm, which is released by Clear once the vote has dropped.
//
// Build option: SENSOR_VOTE_MONITOR_DEBOUNCE_EN (see sensor_debounce).
//
// Parameters:
//   N_SENSORS  number of sensors (2..32)
//   THRESH     active-sensor count that forms a fault vote (1..N_SENSORS)
//   DEBOUNCE   stable cycles before a debounced bit changes (1..255)
//   PERSIST    over-threshold cycles before the alarm latches (1..255)
//
// Ports:
//   Clock   in  rising-edge clock
//   Resetn  in  asynchronous active-low reset
//   X       in  raw sensor inputs, bit i is sensor i+1
//   Enable  in  monitoring enable; low forces IDLE on the next edge
//   Clear   in  single-cycle alarm acknowledge
//   f       out healthy flag, 1 whenever not in ALARM
//   Alarm   out 1 in ALARM, always the inverse of f
//   Count   out registered popcount of the debounced sensor vector
//   Trips   out saturating count of ALARM entries since reset
// -----------------------------------------------------------------------------
module sensor_vote_monitor
  import sensor_vote_pkg::*;
#(
  parameter int N_SENSORS = 7,
  parameter int THRESH    = 6,
  parameter int DEBOUNCE  = 4,
  parameter int PERSIST   = 3
) (
  input  logic                                Clock,
  input  logic                                Resetn,
  input  logic [N_SENSORS-1:0]                X,
  input  logic                                Enable,
  input  logic                                Clear,
  output logic                                f,
  output logic                                Alarm,
  output logic [count_width(N_SENSORS)-1:0]   Count,
  output logic [7:0]                          Trips
);

  localparam int             CW        = count_width(N_SENSORS);
  localparam logic [CW-1:0]  THRESH_C  = CW'(THRESH);
  localparam logic [7:0]     PERSIST_C = 8'(PERSIST);

  logic [N_SENSORS-1:0] db_vec;

  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [7:0]    pers_q, pers_d;
  logic [7:0]    pers_inc;
  logic [7:0]    trips_q, trips_d;
  logic          over_thresh;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_sensor
    sensor_debounce #(
      .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
      .Clock  (Clock),
      .Resetn (Resetn),
      .x_raw  (X[g]),
      .x_db   (db_vec[g])
    );
  end

  // Popcount of the debounced vector; registered so Count trails the vector
  // by exactly one cycle.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      count_d = count_d + {{(CW-1){1'b0}}, db_vec[i]};
    end
  end

  // The vote decision uses the registered Count, matching what the outside
  // world sees on the Count port.
  assign over_thresh = (count_q >= THRESH_C);

  // Next-state logic. Enable low wins over everything else. The PENDING
  // branch checks pers_q against PERSIST first so that with PERSIST=1 a
  // single over-threshold cycle still reaches ALARM even if the vote has
  // already dropped by the time PENDING is evaluated.
  always_comb begin
    state_d  = state_q;
    pers_d   = pers_q;
    trips_d  = trips_q;
    pers_inc = pers_q + 8'd1;
    if (!Enable) begin
      state_d = ST_IDLE;
      pers_d  = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_MONITOR;
          pers_d  = 8'd0;
        end
        ST_MONITOR: begin
          if (over_thresh) begin
            state_d = ST_PENDING;
            pers_d  = 8'd1;
          end
        end
        ST_PENDING: begin
          if (pers_q >= PERSIST_C) begin
            state_d = ST_ALARM;
            if (trips_q != TRIPS_SAT) trips_d = trips_q + 8'd1;
          end else if (over_thresh) begin
            pers_d = pers_inc;
            if (pers_inc >= PERSIST_C) begin
              state_d = ST_ALARM;
              if (trips_q != TRIPS_SAT) trips_d = trips_q + 8'd1;
            end
          end else begin
            state_d = ST_MONITOR;
            pers_d  = 8'd0;
          end
        end
        ST_ALARM: begin
          if (Clear && !over_thresh) begin
            state_d = ST_MONITOR;
            pers_d  = 8'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pers_d  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      pers_q  <= 8'd0;
      trips_q <= 8'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pers_q  <= pers_d;
      trips_q <= trips_d;
      count_q <= count_d;
    end
  end

  // Outputs decode the state register only, so there is no path from
  // X, Clear or Enable to f/Alarm within a cycle.
  assign Alarm = (state_q == ST_ALARM);
  assign f     = ~Alarm;
  assign Count = count_q;
  assign Trips = trips_q;

endmodule
